// File: rtl/pipe_credit_rx.sv
// Credit-returning receive buffer: the far end of a valid-only pipeline lands beats here (optional overflow flag: PIPE_CREDIT_RX_OVF_CHECK_EN).
// Latency: a written beat reaches out_valid one cycle later; credit_out pulses the cycle after each dequeue.
// Backpressure: none upstream (credits bound it); downstream valid/ready; a beat arriving when full with no dequeue is dropped.
module pipe_credit_rx #(
  parameter int WIDTH    = 32,
  parameter int LOGDEPTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  input  logic [WIDTH-1:0]    in_data,
  output logic                credit_out,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [WIDTH-1:0]    out_data,
  output logic [LOGDEPTH:0]   occupancy,
  output logic                ovf_err
);

  localparam int DEPTH = 1 << LOGDEPTH;

  logic [WIDTH-1:0]    mem [DEPTH];
  logic [LOGDEPTH-1:0] wr_ptr;
  logic [LOGDEPTH-1:0] rd_ptr;
  logic                full;
  logic                deq;
  logic                wr_en;

  // Occupancy never exceeds DEPTH, so its MSB alone marks full.
  assign full      = occupancy[LOGDEPTH];
  assign out_valid = (occupancy != '0);
  assign out_data  = mem[rd_ptr];
  assign deq       = out_valid & out_ready;
  assign wr_en     = in_valid & (~full | deq);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      occupancy  <= '0;
      credit_out <= 1'b0;
    end else begin
      credit_out <= deq;
      if (wr_en) wr_ptr <= wr_ptr + LOGDEPTH'(1);
      if (deq)   rd_ptr <= rd_ptr + LOGDEPTH'(1);
      if (wr_en && !deq)
        occupancy <= occupancy + (LOGDEPTH+1)'(1);
      else if (deq && !wr_en)
        occupancy <= occupancy - (LOGDEPTH+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en && !rst) mem[wr_ptr] <= in_data;
  end

`ifdef PIPE_CREDIT_RX_OVF_CHECK_EN
  logic ovf;
  assign ovf = in_valid & full & ~deq;

  always_ff @(posedge clk) begin
    if (rst)      ovf_err <= 1'b0;
    else if (ovf) ovf_err <= 1'b1;
  end
`else
  assign ovf_err = 1'b0;
`endif

endmodule

// File: tb/tb_pipe_credit_rx.sv
// Directed vector table plus hand sequences for fill, full, overflow, wrap and reset.
module tb_pipe_credit_rx;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_data;
  logic        credit_out;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [4:0]  occupancy;
  logic        ovf_err;

`ifdef PIPE_CREDIT_RX_OVF_CHECK_EN
  localparam logic EXP_OVF = 1'b1;
`else
  localparam logic EXP_OVF = 1'b0;
`endif

  int errors = 0;
  int checks = 0;

  pipe_credit_rx #(.WIDTH(32), .LOGDEPTH(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .credit_out(credit_out), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .occupancy(occupancy), .ovf_err(ovf_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic iv, input logic [31:0] d, input logic rdy);
    rst = r; in_valid = iv; in_data = d; out_ready = rdy;
  endtask

  typedef struct {
    logic        rst;
    logic        iv;
    logic [31:0] din;
    logic        rdy;
    logic        ev;
    logic [31:0] edat;
    logic [4:0]  eocc;
    logic        ecr;
  } vec_t;

  vec_t vecs[12];
  logic [31:0] q[$];

  initial begin
    // inputs applied for one edge; expectations are the state after that edge
    vecs[0]  = '{1, 0, 32'h0,        0, 0, 32'h0,        5'd0, 0};
    vecs[1]  = '{0, 1, 32'hA5A5A5A5, 1, 1, 32'hA5A5A5A5, 5'd1, 0};
    vecs[2]  = '{0, 0, 32'h0,        1, 0, 32'h0,        5'd0, 1};
    vecs[3]  = '{0, 0, 32'h0,        0, 0, 32'h0,        5'd0, 0};
    vecs[4]  = '{0, 1, 32'h11,       0, 1, 32'h11,       5'd1, 0};
    vecs[5]  = '{0, 1, 32'h22,       0, 1, 32'h11,       5'd2, 0};
    vecs[6]  = '{0, 1, 32'h33,       1, 1, 32'h22,       5'd2, 1};
    vecs[7]  = '{0, 0, 32'h0,        1, 1, 32'h33,       5'd1, 1};
    vecs[8]  = '{0, 0, 32'h0,        0, 1, 32'h33,       5'd1, 0};
    vecs[9]  = '{0, 0, 32'h0,        1, 0, 32'h0,        5'd0, 1};
    vecs[10] = '{0, 0, 32'h0,        1, 0, 32'h0,        5'd0, 0};
    vecs[11] = '{1, 1, 32'h77,       1, 0, 32'h0,        5'd0, 0};

    drive(1, 0, 0, 0);
    for (int i = 0; i < 12; i++) begin
      drive(vecs[i].rst, vecs[i].iv, vecs[i].din, vecs[i].rdy);
      step();
      chk($sformatf("vec%0d_occ", i), occupancy, vecs[i].eocc);
      chk($sformatf("vec%0d_valid", i), out_valid, vecs[i].ev);
      chk($sformatf("vec%0d_credit", i), credit_out, vecs[i].ecr);
      if (vecs[i].ev) chk($sformatf("vec%0d_data", i), out_data, vecs[i].edat);
    end
    chk("vec_ovf_err", ovf_err, 0);

    // Fill 16 with downstream stalled, then drain in order
    drive(0, 0, 0, 0);
    for (int i = 0; i < 16; i++) begin
      drive(0, 1, 32'(i), 0);
      step();
      chk($sformatf("fill%0d_credit", i), credit_out, 0);
    end
    chk("fill_occ", occupancy, 16);
    chk("fill_valid", out_valid, 1);
    drive(0, 0, 0, 1);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("drain%0d_data", i), out_data, 32'(i));
      step();
      chk($sformatf("drain%0d_credit", i), credit_out, 1);
    end
    chk("drain_occ", occupancy, 0);
    step();
    chk("drain_credit_end", credit_out, 0);

    // Full with simultaneous dequeue: accepted, occupancy stays 16
    for (int i = 0; i < 16; i++) begin
      drive(0, 1, 32'(i), 0);
      step();
    end
    drive(0, 1, 32'h100, 1);
    chk("fullsim_head", out_data, 0);
    step();
    chk("fullsim_occ", occupancy, 16);
    chk("fullsim_credit", credit_out, 1);
    chk("fullsim_ovf", ovf_err, 0);

    // Overflow: beat dropped, flag sticky when built
    drive(0, 1, 32'hDEAD, 0);
    step();
    chk("ovf_occ", occupancy, 16);
    chk("ovf_flag", ovf_err, EXP_OVF);
    chk("ovf_credit", credit_out, 0);
    drive(0, 0, 0, 0);
    step();
    chk("ovf_sticky", ovf_err, EXP_OVF);
    drive(0, 0, 0, 1);
    for (int i = 1; i < 16; i++) begin
      chk($sformatf("ovfdrain%0d_data", i), out_data, 32'(i));
      step();
    end
    chk("ovfdrain_last", out_data, 32'h100);
    step();
    chk("ovfdrain_occ", occupancy, 0);
    chk("ovf_sticky2", ovf_err, EXP_OVF);

    // Reset clears flag, then stream 40 beats with random stalls
    drive(1, 0, 0, 0);
    step();
    chk("rst_ovf", ovf_err, 0);
    begin
      int sent = 0, deqs = 0, credits = 0;
      logic iv, rdy, deq_m;
      q.delete();
      for (int cyc = 0; cyc < 1000 && !(sent == 40 && q.size() == 0); cyc++) begin
        iv    = (sent < 40) && (q.size() < 16) && ($urandom_range(0, 3) != 0);
        rdy   = ($urandom_range(0, 2) != 0);
        deq_m = (q.size() != 0) && rdy;
        drive(0, iv, 32'hC000_0000 + 32'(sent), rdy);
        chk("stream_valid", out_valid, q.size() != 0);
        if (deq_m) chk("stream_data", out_data, q[0]);
        step();
        if (deq_m) begin
          void'(q.pop_front());
          deqs++;
        end
        if (iv) begin
          q.push_back(32'hC000_0000 + 32'(sent));
          sent++;
        end
        if (credit_out) credits++;
        chk("stream_occ", occupancy, q.size());
      end
      chk("stream_done", (sent == 40 && q.size() == 0), 1);
      chk("stream_deqs", deqs, 40);
      chk("stream_credits", credits, deqs);
    end

    // Reset mid-stream with 5 stored and a credit pulse in flight
    drive(0, 0, 0, 0);
    step();
    for (int i = 0; i < 6; i++) begin
      drive(0, 1, 32'h50 + 32'(i), 0);
      step();
    end
    drive(0, 0, 0, 1);
    step();
    chk("midrst_pre_occ", occupancy, 5);
    chk("midrst_pre_credit", credit_out, 1);
    drive(1, 1, 32'h99, 1);
    step();
    chk("midrst_occ", occupancy, 0);
    chk("midrst_valid", out_valid, 0);
    chk("midrst_credit", credit_out, 0);
    drive(0, 1, 32'h1234, 1);
    step();
    chk("postrst_occ", occupancy, 1);
    chk("postrst_data", out_data, 32'h1234);
    chk("postrst_credit", credit_out, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
